// File: rtl/reset_sequencer_pkg.sv
// Shared reset-sequencer types and default constants (also used by the clock manager).
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Holds the sequencer state enum, default parameter values and the lock-loss
// counter width. The RESTART state only exists when RESET_SEQ_WATCHDOG_EN is defined.
package reset_sequencer_pkg;

  localparam int DEF_NUM_STAGES      = 3;
  localparam int DEF_STABLE_CYCLES   = 64;
  localparam int DEF_STAGE_GAP       = 16;
  localparam int DEF_WATCHDOG_CYCLES = 1000000;
  localparam int DEF_MMCM_RST_CYCLES = 8;

  localparam int LOCK_LOSS_CNT_W     = 8;

  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RELEASE   = 3'd3,
`ifdef RESET_SEQ_WATCHDOG_EN
    ST_RUN       = 3'd4,
    ST_RESTART   = 3'd5
`else
    ST_RUN       = 3'd4
`endif
  } reset_seq_state_e;

endpackage

// File: rtl/reset_sequencer_if.sv
// Bundle of lock/request inputs and staged reset outputs of the reset sequencer.
// Latency: n/a (wires only).
// Backpressure: none; all signals are level or single-cycle pulses.
//
// Ports (signals):
//   clk_locked    lock flag synchronous to clk        (into sequencer)
//   ext_rst_req   single-cycle re-sequence request    (into sequencer)
//   rst_out       per-stage active-high resets        (from sequencer)
//   seq_done      all stages released, lock held      (from sequencer)
//   mmcm_rst      MMCM reset request                  (from sequencer)
//   lock_loss_cnt saturating lock-drop count          (from sequencer)
// master = sequencer side, slave = consumer/stimulus side.
interface reset_sequencer_if #(
  parameter int NUM_STAGES = 3
);
  import reset_sequencer_pkg::*;

  logic                       clk_locked;
  logic                       ext_rst_req;
  logic [NUM_STAGES-1:0]      rst_out;
  logic                       seq_done;
  logic                       mmcm_rst;
  logic [LOCK_LOSS_CNT_W-1:0] lock_loss_cnt;

  modport master (
    input  clk_locked,
    input  ext_rst_req,
    output rst_out,
    output seq_done,
    output mmcm_rst,
    output lock_loss_cnt
  );

  modport slave (
    output clk_locked,
    output ext_rst_req,
    input  rst_out,
    input  seq_done,
    input  mmcm_rst,
    input  lock_loss_cnt
  );

endinterface

// File: rtl/reset_sequencer.sv
// Staged reset release after proven PLL/MMCM lock, with optional MMCM restart watchdog.
// Latency: all outputs registered; aborts (lock drop / request / rst) take effect on the next edge.
// Backpressure: none; inputs are sampled every cycle.
//
// Ports:
//   clk  system clock;  rst  synchronous active-high reset
//   bus  reset_sequencer_if.master: clk_locked, ext_rst_req in; rst_out, seq_done,
//        mmcm_rst, lock_loss_cnt out
// Build option: define RESET_SEQ_WATCHDOG_EN to add the lock watchdog and RESTART state
// (otherwise mmcm_rst is tied low and the sequencer may wait for lock forever).
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int NUM_STAGES      = DEF_NUM_STAGES,
  parameter int STABLE_CYCLES   = DEF_STABLE_CYCLES,
  parameter int STAGE_GAP       = DEF_STAGE_GAP,
  parameter int WATCHDOG_CYCLES = DEF_WATCHDOG_CYCLES,
  parameter int MMCM_RST_CYCLES = DEF_MMCM_RST_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  reset_sequencer_if.master bus
);

  localparam int STABLE_W = $clog2(STABLE_CYCLES + 1);
  localparam int GAP_W    = $clog2(STAGE_GAP + 1);
  localparam int IDX_W    = $clog2(NUM_STAGES + 1);

  // Counters stop one short of the parameter: the edge on which they would
  // reach it is the edge that takes the transition.
  localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(STABLE_CYCLES - 1);
  localparam logic [GAP_W-1:0]    GAP_LAST    = GAP_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST    = IDX_W'(NUM_STAGES);

  if (NUM_STAGES < 1 || STABLE_CYCLES < 1 || STAGE_GAP < 1 ||
      WATCHDOG_CYCLES < 1 || MMCM_RST_CYCLES < 1) begin : g_bad_params
    $error("reset_sequencer: every parameter must be at least 1");
  end

  reset_seq_state_e           state_q, state_d;
  logic [STABLE_W-1:0]        stable_q, stable_d;
  logic [GAP_W-1:0]           gap_q, gap_d;
  // Number of stages already released while in RELEASE.
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [LOCK_LOSS_CNT_W-1:0] loss_q, loss_d;
  logic [NUM_STAGES-1:0]      rst_out_q, rst_out_d;
  logic                       seq_done_q, seq_done_d;

`ifdef RESET_SEQ_WATCHDOG_EN
  localparam int WD_W    = $clog2(WATCHDOG_CYCLES + 1);
  localparam int PULSE_W = $clog2(MMCM_RST_CYCLES + 1);
  localparam logic [WD_W-1:0]    WD_LAST    = WD_W'(WATCHDOG_CYCLES - 1);
  localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(MMCM_RST_CYCLES - 1);

  logic [WD_W-1:0]    wd_q, wd_d;
  logic [PULSE_W-1:0] pulse_q, pulse_d;
  logic               mmcm_rst_q, mmcm_rst_d;
`endif

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_HOLD;
      stable_q   <= '0;
      gap_q      <= '0;
      idx_q      <= '0;
      loss_q     <= '0;
      rst_out_q  <= '1;
      seq_done_q <= 1'b0;
`ifdef RESET_SEQ_WATCHDOG_EN
      wd_q       <= '0;
      pulse_q    <= '0;
      mmcm_rst_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      stable_q   <= stable_d;
      gap_q      <= gap_d;
      idx_q      <= idx_d;
      loss_q     <= loss_d;
      rst_out_q  <= rst_out_d;
      seq_done_q <= seq_done_d;
`ifdef RESET_SEQ_WATCHDOG_EN
      wd_q       <= wd_d;
      pulse_q    <= pulse_d;
      mmcm_rst_q <= mmcm_rst_d;
`endif
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_d  = state_q;
    stable_d = stable_q;
    gap_d    = gap_q;
    idx_d    = idx_q;
    loss_d   = loss_q;
`ifdef RESET_SEQ_WATCHDOG_EN
    wd_d     = wd_q;
    pulse_d  = pulse_q;
`endif

    case (state_q)
      ST_HOLD: state_d = ST_WAIT_LOCK;

      // A request here is an abort back to the same state, so it simply blocks entry.
      ST_WAIT_LOCK: begin
        if (!bus.ext_rst_req && bus.clk_locked) begin
          state_d  = ST_STABLE;
          stable_d = '0;
        end
      end

      ST_STABLE: begin
        if (!bus.clk_locked || bus.ext_rst_req) begin
          state_d  = ST_WAIT_LOCK;
          stable_d = '0;
        end else if (stable_q == STABLE_LAST) begin
          // Stage 0 is released on this same edge.
          state_d  = ST_RELEASE;
          stable_d = '0;
          gap_d    = '0;
          idx_d    = IDX_W'(1);
        end else begin
          stable_d = stable_q + 1'b1;
        end
      end

      ST_RELEASE, ST_RUN: begin
        if (!bus.clk_locked || bus.ext_rst_req) begin
          state_d = ST_WAIT_LOCK;
          gap_d   = '0;
          idx_d   = '0;
          // Only lock drops are counted; a coincident request counts once.
          if (!bus.clk_locked && loss_q != '1) begin
            loss_d = loss_q + 1'b1;
          end
        end else if (state_q == ST_RELEASE) begin
          if (gap_q == GAP_LAST) begin
            gap_d = '0;
            if (idx_q == IDX_LAST) begin
              state_d = ST_RUN;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end

`ifdef RESET_SEQ_WATCHDOG_EN
      // Lock and requests are ignored until the MMCM pulse completes.
      ST_RESTART: begin
        if (pulse_q == PULSE_LAST) begin
          state_d = ST_WAIT_LOCK;
          pulse_d = '0;
          wd_d    = '0;
        end else begin
          pulse_d = pulse_q + 1'b1;
        end
      end
`endif

      default: state_d = ST_HOLD;
    endcase

`ifdef RESET_SEQ_WATCHDOG_EN
    // The watchdog spans lock bounces, so it is only cleared on reaching
    // RELEASE or leaving RESTART. Expiry overrides any other transition.
    if (state_q == ST_WAIT_LOCK || state_q == ST_STABLE) begin
      wd_d = wd_q + 1'b1;
      if (wd_q == WD_LAST) begin
        state_d  = ST_RESTART;
        stable_d = '0;
        gap_d    = '0;
        idx_d    = '0;
        pulse_d  = '0;
      end else if (state_d == ST_RELEASE) begin
        wd_d = '0;
      end
    end
`endif
  end

  // ---------------------------------------------------------------- outputs
  // Decoded from the next state so every output is a flop with the same
  // one-edge reaction to inputs.
  always_comb begin
    rst_out_d  = '1;
    seq_done_d = 1'b0;
`ifdef RESET_SEQ_WATCHDOG_EN
    mmcm_rst_d = 1'b0;
`endif
    case (state_d)
      ST_RELEASE: begin
        for (int k = 0; k < NUM_STAGES; k++) begin
          rst_out_d[k] = (k >= int'(idx_d));
        end
      end
      ST_RUN: begin
        rst_out_d  = '0;
        seq_done_d = 1'b1;
      end
`ifdef RESET_SEQ_WATCHDOG_EN
      ST_RESTART: mmcm_rst_d = 1'b1;
`endif
      default: ;
    endcase
  end

  assign bus.rst_out       = rst_out_q;
  assign bus.seq_done      = seq_done_q;
  assign bus.lock_loss_cnt = loss_q;
`ifdef RESET_SEQ_WATCHDOG_EN
  assign bus.mmcm_rst      = mmcm_rst_q;
`else
  assign bus.mmcm_rst      = 1'b0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Testbench for reset_sequencer: directed timeline checks plus randomized lock/request/reset
// traffic compared every cycle against a timeline model (cycles since lock became stable).
// Summary: Result: errors=<n> of <m> checks
module tb_reset_sequencer;

  localparam int S      = 8;
  localparam int G      = 4;
  localparam int N      = 3;
  localparam int W      = 100;
  localparam int P      = 8;
  localparam int DONE_T = S + N * G;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  always #5 clk = ~clk;

  reset_sequencer_if #(.NUM_STAGES(N)) bus ();

  reset_sequencer #(
    .NUM_STAGES     (N),
    .STABLE_CYCLES  (S),
    .STAGE_GAP      (G),
    .WATCHDOG_CYCLES(W),
    .MMCM_RST_CYCLES(P)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------- model
  // m_t = edges since lock was first seen stable (-1 = not sequencing).
  bit m_hold = 1'b1;
  int m_t    = -1;
  int m_loss = 0;
  int m_wd   = 0;
  int m_left = 0;   // remaining MMCM restart pulse cycles
  int nt;
  bit waiting;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_hold = 1'b1; m_t = -1; m_loss = 0; m_wd = 0; m_left = 0;
    end else if (m_hold) begin
      m_hold = 1'b0; m_t = -1;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) m_wd = 0;
    end else begin
      waiting = (m_t < S);
      if (m_t >= 0 && !bus.clk_locked) begin
        if (m_t >= S && m_loss < 255) m_loss++;
        nt = -1;
      end else if (bus.ext_rst_req) begin
        nt = -1;
      end else if (m_t >= 0) begin
        nt = (m_t < DONE_T) ? m_t + 1 : DONE_T;
      end else if (bus.clk_locked) begin
        nt = 0;
      end else begin
        nt = -1;
      end
`ifdef RESET_SEQ_WATCHDOG_EN
      if (waiting) begin
        m_wd++;
        if (m_wd == W) begin
          m_left = P;
          nt = -1;
        end
      end
      if (nt == S) m_wd = 0;
`endif
      m_t = nt;
    end
  end

  function automatic logic [N-1:0] exp_rst_out();
    logic [N-1:0] e;
    for (int k = 0; k < N; k++) e[k] = (m_t < S + k * G);
    return e;
  endfunction

  always @(negedge clk) begin
    chk("rst_out", 32'(bus.rst_out), 32'(exp_rst_out()));
    chk("seq_done", 32'(bus.seq_done), 32'(m_t >= DONE_T));
    chk("mmcm_rst", 32'(bus.mmcm_rst), 32'(m_left > 0));
    chk("lock_loss_cnt", 32'(bus.lock_loss_cnt), 32'(m_loss));
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    rst = 1'b1;
    bus.clk_locked  = 1'b0;
    bus.ext_rst_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_rst_out", 32'(bus.rst_out), 32'h7);
    chk("reset_seq_done", 32'(bus.seq_done), 32'h0);
    chk("reset_mmcm_rst", 32'(bus.mmcm_rst), 32'h0);
    chk("reset_loss", 32'(bus.lock_loss_cnt), 32'h0);

    // 1: basic release timeline
    rst = 1'b0;
    @(negedge clk);                      // HOLD -> WAIT_LOCK edge
    bus.clk_locked = 1'b1;
    @(negedge clk);                      // edge T
    repeat (7) @(negedge clk);
    chk("t1_T+7_rst_out", 32'(bus.rst_out), 32'h7);
    @(negedge clk);
    chk("t1_T+8_rst_out", 32'(bus.rst_out), 32'h6);
    repeat (4) @(negedge clk);
    chk("t1_T+12_rst_out", 32'(bus.rst_out), 32'h4);
    repeat (4) @(negedge clk);
    chk("t1_T+16_rst_out", 32'(bus.rst_out), 32'h0);
    chk("t1_T+16_seq_done", 32'(bus.seq_done), 32'h0);
    repeat (3) @(negedge clk);
    chk("t1_T+19_seq_done", 32'(bus.seq_done), 32'h0);
    @(negedge clk);
    chk("t1_T+20_seq_done", 32'(bus.seq_done), 32'h1);

    // 4: external request in RUN
    bus.ext_rst_req = 1'b1;
    @(negedge clk);
    bus.ext_rst_req = 1'b0;
    chk("t4_rst_out", 32'(bus.rst_out), 32'h7);
    chk("t4_seq_done", 32'(bus.seq_done), 32'h0);
    chk("t4_loss", 32'(bus.lock_loss_cnt), 32'h0);
    @(negedge clk);                      // new T
    repeat (19) @(negedge clk);
    chk("t4_T+19_seq_done", 32'(bus.seq_done), 32'h0);
    @(negedge clk);
    chk("t4_T+20_seq_done", 32'(bus.seq_done), 32'h1);

    // 3: lock drop in RUN
    bus.clk_locked = 1'b0;
    @(negedge clk);
    chk("t3_rst_out", 32'(bus.rst_out), 32'h7);
    chk("t3_seq_done", 32'(bus.seq_done), 32'h0);
    chk("t3_loss", 32'(bus.lock_loss_cnt), 32'h1);

    // 2: one-cycle glitch during STABLE
    bus.clk_locked = 1'b1;
    @(negedge clk);                      // T
    repeat (4) @(negedge clk);
    bus.clk_locked = 1'b0;               // sampled at T+5
    @(negedge clk);
    bus.clk_locked = 1'b1;
    @(negedge clk);                      // T' = T+6
    repeat (2) @(negedge clk);
    chk("t2_T+8_rst_out", 32'(bus.rst_out), 32'h7);
    repeat (5) @(negedge clk);
    chk("t2_Tp+7_rst_out", 32'(bus.rst_out), 32'h7);
    @(negedge clk);
    chk("t2_Tp+8_rst_out", 32'(bus.rst_out), 32'h6);

    // 6: rst in the middle of RELEASE
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_out", 32'(bus.rst_out), 32'h7);
    chk("t6_seq_done", 32'(bus.seq_done), 32'h0);
    chk("t6_loss", 32'(bus.lock_loss_cnt), 32'h0);
    chk("t6_mmcm_rst", 32'(bus.mmcm_rst), 32'h0);
    rst = 1'b0;

    // 3b: loss counter saturation
    for (int i = 0; i < 260; i++) begin
      bus.clk_locked = 1'b1;
      repeat (10) @(negedge clk);
      bus.clk_locked = 1'b0;
      @(negedge clk);
    end
    chk("t3_loss_sat", 32'(bus.lock_loss_cnt), 32'd255);

`ifdef RESET_SEQ_WATCHDOG_EN
    // 5: watchdog restart with lock held low
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);                      // WAIT_LOCK entry edge E
    repeat (99) @(negedge clk);
    chk("t5_E+99_mmcm", 32'(bus.mmcm_rst), 32'h0);
    @(negedge clk);
    chk("t5_E+100_mmcm", 32'(bus.mmcm_rst), 32'h1);
    repeat (7) @(negedge clk);
    chk("t5_E+107_mmcm", 32'(bus.mmcm_rst), 32'h1);
    @(negedge clk);
    chk("t5_E+108_mmcm", 32'(bus.mmcm_rst), 32'h0);
    repeat (100) @(negedge clk);
    chk("t5_E+208_mmcm", 32'(bus.mmcm_rst), 32'h1);
`endif

    // randomized traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      bus.clk_locked  = ($urandom_range(0, 63) != 0);
      bus.ext_rst_req = ($urandom_range(0, 49) == 0);
      rst             = ($urandom_range(0, 499) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.ext_rst_req = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
